// File: rtl/right_barrel_shifter_seq.sv
// Iterative logarithmic right shifter (SRL/SRLI zero fill, SRA/SRAI sign fill).
// Latency: result valid 6 edges after the accepting edge (5 stage cycles + result register).
// Backpressure: single operation in flight; result held in DONE until out_ready, no input accept while busy.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   in_valid/ready   operand handshake; water/shift/arith sampled only on accept
//   water            value to shift
//   shift            shift amount, only shift[SHW-1:0] used
//   arith            1 = sign fill, 0 = zero fill
//   out_valid/ready  result handshake
//   wine             shifted result, held until the next operation completes
//   busy             high while an operation is in SHIFT or DONE
module right_barrel_shifter_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] water,
  input  logic [WIDTH-1:0] shift,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] wine,
  output logic             busy
);

  // Stage counter runs 0..SHW: values below SHW apply stage k, value SHW
  // commits the accumulator to the output register.
  localparam int KW = $clog2(SHW + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHW-1:0]     amt_q, amt_d;
  logic               fill_q, fill_d;
  logic [KW-1:0]      k_q, k_d;
  logic [WIDTH-1:0]   wine_q, wine_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;

  // Fill bits are prepended above the accumulator so a plain logical shift
  // of the double-width word pulls them into the vacated upper positions.
  logic [2*WIDTH-1:0] ext_sh;
  logic               stage_en;

  always_comb begin
    ext_sh   = {{WIDTH{fill_q}}, acc_q} >> (32'd1 << k_q);
    stage_en = 1'b0;
    if (k_q < KW'(SHW)) begin
      stage_en = amt_q[k_q];
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    amt_d       = amt_q;
    fill_d      = fill_q;
    k_d         = k_q;
    wine_d      = wine_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          acc_d      = water;
          amt_d      = shift[SHW-1:0];
          // Sign captured now so later changes on water cannot leak in.
          fill_d     = arith & water[WIDTH-1];
          k_d        = '0;
          state_d    = SHIFT;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      SHIFT: begin
        if (k_q == KW'(SHW)) begin
          wine_d      = acc_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          // Every stage takes a cycle even when its amount bit is clear,
          // so latency is independent of the shift amount.
          if (stage_en) begin
            acc_d = ext_sh[WIDTH-1:0];
          end
          k_d = k_q + KW'(1);
        end
      end

      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      amt_q       <= '0;
      fill_q      <= 1'b0;
      k_q         <= '0;
      wine_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      amt_q       <= amt_d;
      fill_q      <= fill_d;
      k_q         <= k_d;
      wine_q      <= wine_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign wine      = wine_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_right_barrel_shifter_seq.sv
// Directed bench for right_barrel_shifter_seq: hand-computed results, latency,
// backpressure, asynchronous reset mid-operation and back-to-back operands.
module tb_right_barrel_shifter_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] water;
  logic [31:0] shift;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] wine;
  logic        busy;

  int n_cmp;
  int n_bad;

  right_barrel_shifter_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .water     (water),
    .shift     (shift),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wine      (wine),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Counts edges from the current point (just after the accepting edge)
  // until out_valid is seen, bounded so a stuck DUT still ends the run.
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // Accepts one operand, scrambles the inputs after acceptance, then checks
  // latency and result. Leaves the bench just after the edge raising out_valid.
  task automatic run_op(input string tag, input logic [31:0] w, input logic [31:0] s,
                        input logic a, input logic [31:0] exp);
    int edges;
    @(negedge clk);
    check_eq({tag, "_rdy_before"}, {31'd0, in_ready}, 32'd1);
    water    = w;
    shift    = s;
    arith    = a;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    water    = ~w;
    shift    = ~s;
    arith    = ~a;
    check_eq({tag, "_busy_acc"}, {30'd0, busy, in_ready}, 32'd2);
    wait_valid(edges);
    check_eq({tag, "_lat"}, edges, 32'd6);
    check_eq({tag, "_wine"}, wine, exp);
  endtask

  // Consumer already ready: handshake completes on the next edge.
  task automatic finish_op(input string tag);
    @(posedge clk);
    #1;
    check_eq({tag, "_done"}, {29'd0, out_valid, in_ready, busy}, 32'd2);
  endtask

  initial begin
    int edges;
    int seen;
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    water     = 32'h0;
    shift     = 32'h0;
    arith     = 1'b0;
    out_ready = 1'b1;

    #3;
    check_eq("rst_flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
    check_eq("rst_wine", wine, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Logical shift by the maximum amount; result pulse lasts one cycle.
    run_op("srl31", 32'h8000_0000, 32'd31, 1'b0, 32'h0000_0001);
    finish_op("srl31");

    run_op("sra4", 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000);
    finish_op("sra4");
    run_op("srl4", 32'h8000_0000, 32'd4, 1'b0, 32'h0800_0000);
    finish_op("srl4");

    // Only the low five shift bits matter.
    run_op("upper_ign", 32'h0000_0004, 32'h0000_0021, 1'b0, 32'h0000_0002);
    finish_op("upper_ign");
    run_op("sra0", 32'hDEAD_BEEF, 32'd0, 1'b1, 32'hDEAD_BEEF);
    finish_op("sra0");
    run_op("sra31_neg", 32'h8000_0000, 32'd31, 1'b1, 32'hFFFF_FFFF);
    finish_op("sra31_neg");
    run_op("sra31_pos", 32'h7FFF_FFFF, 32'd31, 1'b1, 32'h0000_0000);
    finish_op("sra31_pos");
    run_op("srl16", 32'h1234_5678, 32'd16, 1'b0, 32'h0000_1234);
    finish_op("srl16");

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    run_op("bp", 32'hFFFF_0000, 32'd8, 1'b1, 32'hFFFF_FF00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_hold_wine", wine, 32'hFFFF_FF00);
      check_eq("bp_hold_flags", {30'd0, out_valid, in_ready}, 32'd2);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
    check_eq("bp_wine_idle", wine, 32'hFFFF_FF00);

    // Asynchronous reset during the third SHIFT cycle.
    @(negedge clk);
    water    = 32'hF000_0000;
    shift    = 32'd3;
    arith    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
    check_eq("arst_wine", wine, 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check_eq("arst_no_pulse", seen, 32'd0);

    // Back-to-back with in_valid held high throughout.
    @(negedge clk);
    water    = 32'h0000_0100;
    shift    = 32'd8;
    arith    = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    water = 32'h8000_0001;
    shift = 32'd1;
    arith = 1'b1;
    wait_valid(edges);
    check_eq("b2b_lat1", edges, 32'd6);
    check_eq("b2b_wine1", wine, 32'h0000_0001);
    @(posedge clk);
    #1;
    check_eq("b2b_hs1", {29'd0, out_valid, in_ready, busy}, 32'd2);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("b2b_acc2", {30'd0, in_ready, busy}, 32'd1);
    wait_valid(edges);
    check_eq("b2b_lat2", edges, 32'd6);
    check_eq("b2b_wine2", wine, 32'hC000_0000);
    finish_op("b2b2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
